// File: rtl/spinner_multi_if.sv
// Bus bundle for spinner_multi: per-channel rotate requests, spinner/mouse
// delta streams in, frame-sampled positions out.
interface spinner_multi_if #(
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 8
);
  logic                      strobe;
  logic [CHANNELS-1:0]       minus;
  logic [CHANNELS-1:0]       plus;
  logic [CHANNELS-1:0]       fast;
  logic [9*CHANNELS-1:0]     spin_in;
  logic [8:0]                mouse_in;
  logic [OUT_W*CHANNELS-1:0] spin_out;
  logic                      spin_valid;
  logic                      mouse_active;

  modport master (
    output strobe, minus, plus, fast, spin_in, mouse_in,
    input  spin_out, spin_valid, mouse_active
  );

  modport slave (
    input  strobe, minus, plus, fast, spin_in, mouse_in,
    output spin_out, spin_valid, mouse_active
  );
endinterface

// File: rtl/spinner_multi.sv
// Multi-channel rotary accumulator: digital steps, spinner deltas and mouse
// deltas merge into wrapping positions sampled on each frame strobe edge.
module spinner_multi #(
  parameter int CHANNELS  = 2,
  parameter int OUT_W     = 8,
  parameter int STEP      = 1,
  parameter int FAST_STEP = 4,
  parameter int RATE_DIV  = 5,
  parameter int MOUSE_CH  = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  spinner_multi_if.slave bus
);

  localparam int DIV_W = $clog2(RATE_DIV) + 1;

  logic [OUT_W-1:0]          pos_q [CHANNELS];
  logic [OUT_W-1:0]          pos_d [CHANNELS];
  logic [DIV_W-1:0]          div_q [CHANNELS];
  logic [DIV_W-1:0]          div_d [CHANNELS];
  logic [CHANNELS-1:0]       prev_tog_q, prev_tog_d;
  logic                      prev_mtog_q, prev_mtog_d;
  logic                      mouse_active_q, mouse_active_d;
  logic                      strobe_q, strobe_d;
  logic                      primed_q, primed_d;
  logic [OUT_W*CHANNELS-1:0] spin_out_q, spin_out_d;
  logic                      spin_valid_q, spin_valid_d;

  logic                      sedge_s;
  logic                      mouse_tog_s;
  logic [OUT_W-1:0]          mdelta_s;
  logic [CHANNELS-1:0]       spin_tog_s;
  logic [OUT_W-1:0]          sdelta_s [CHANNELS];
  logic [OUT_W-1:0]          dstep_s  [CHANNELS];
  logic [OUT_W-1:0]          adelta_s [CHANNELS];
  logic [OUT_W-1:0]          step_mag_s;

  // Next-state: edge detect, toggle detect, source select, per-channel sums.
  always_comb begin
    strobe_d     = bus.strobe;
    prev_tog_d   = prev_tog_q;
    prev_mtog_d  = bus.mouse_in[8];
    primed_d     = 1'b1;
    spin_out_d   = spin_out_q;
    step_mag_s   = '0;

    // Toggles are masked in the priming cycle so a flag already set at
    // reset release is absorbed into prev_* without producing a delta.
    sedge_s      = bus.strobe & ~strobe_q & primed_q;
    mouse_tog_s  = primed_q & (bus.mouse_in[8] != prev_mtog_q);
    mdelta_s     = OUT_W'($signed(bus.mouse_in[7:0]));

    for (int ch = 0; ch < CHANNELS; ch++) begin
      prev_tog_d[ch] = bus.spin_in[9*ch+8];
      spin_tog_s[ch] = primed_q & (bus.spin_in[9*ch+8] != prev_tog_q[ch]);
      sdelta_s[ch]   = OUT_W'($signed(bus.spin_in[9*ch +: 8]));
    end

    if (spin_tog_s[MOUSE_CH]) begin
      mouse_active_d = 1'b0;
    end else if (mouse_tog_s) begin
      mouse_active_d = 1'b1;
    end else begin
      mouse_active_d = mouse_active_q;
    end

    for (int ch = 0; ch < CHANNELS; ch++) begin
      dstep_s[ch] = '0;
      div_d[ch]   = div_q[ch];
      if (sedge_s) begin
        if (bus.plus[ch] ^ bus.minus[ch]) begin
          if (div_q[ch] == DIV_W'(RATE_DIV - 1)) begin
            div_d[ch]   = '0;
            step_mag_s  = bus.fast[ch] ? OUT_W'(FAST_STEP) : OUT_W'(STEP);
            dstep_s[ch] = bus.plus[ch] ? step_mag_s : (OUT_W'(0) - step_mag_s);
          end else begin
            div_d[ch] = div_q[ch] + DIV_W'(1);
          end
        end else begin
          div_d[ch] = '0;
        end
      end else begin
        div_d[ch] = div_q[ch];
      end

      if ((ch == MOUSE_CH) && mouse_active_d) begin
        adelta_s[ch] = mouse_tog_s ? mdelta_s : '0;
      end else begin
        adelta_s[ch] = spin_tog_s[ch] ? sdelta_s[ch] : '0;
      end

      pos_d[ch] = pos_q[ch] + dstep_s[ch] + adelta_s[ch];
      if (sedge_s) begin
        spin_out_d[ch*OUT_W +: OUT_W] = pos_d[ch];
      end else begin
        spin_out_d[ch*OUT_W +: OUT_W] = spin_out_q[ch*OUT_W +: OUT_W];
      end
    end

    spin_valid_d = sedge_s;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        pos_q[ch] <= '0;
        div_q[ch] <= '0;
      end
      prev_tog_q     <= '0;
      prev_mtog_q    <= 1'b0;
      mouse_active_q <= 1'b0;
      strobe_q       <= 1'b0;
      primed_q       <= 1'b0;
      spin_out_q     <= '0;
      spin_valid_q   <= 1'b0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        pos_q[ch] <= pos_d[ch];
        div_q[ch] <= div_d[ch];
      end
      prev_tog_q     <= prev_tog_d;
      prev_mtog_q    <= prev_mtog_d;
      mouse_active_q <= mouse_active_d;
      strobe_q       <= strobe_d;
      primed_q       <= primed_d;
      spin_out_q     <= spin_out_d;
      spin_valid_q   <= spin_valid_d;
    end
  end

  assign bus.spin_out     = spin_out_q;
  assign bus.spin_valid   = spin_valid_q;
  assign bus.mouse_active = mouse_active_q;

endmodule
